// File: rtl/llc_lookup_pipe_pkg.sv
// Shared LLC types and constants for the set lookup pipeline.
// Holds the line-state encoding, request mode encodings, cache-ID width and FSM states.
package llc_lookup_pipe_pkg;

  localparam int unsigned LLC_ID_WIDTH = 5;

  typedef enum logic [2:0] {
    LLC_I  = 3'd0,
    LLC_V  = 3'd1,
    LLC_S  = 3'd2,
    LLC_D  = 3'd3,
    LLC_SD = 3'd4
  } llc_state_t;

  localparam logic [1:0] REQ_LOOKUP      = 2'd0;
  localparam logic [1:0] REQ_LOOKUP_SCAN = 2'd1;
  localparam logic [1:0] REQ_EVICT_SCAN  = 2'd2;
  localparam logic [1:0] REQ_RSVD        = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StResp,
    StScan
  } lookup_fsm_e;

endpackage

// File: rtl/llc_owned_word_scanner.sv
// Steps through an owned-word mask lowest bit first, one word per accepted beat.
// word_o is the lowest set bit; last_o flags that it is the only one left.
module llc_owned_word_scanner #(
  parameter int unsigned WORDS = 4,
  localparam int unsigned WORD_W = $clog2(WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WORDS-1:0]  mask_i,
  input  logic              step_i,
  output logic [WORD_W-1:0] word_o,
  output logic              last_o
);

  logic [WORDS-1:0] mask_d, mask_q;
  logic [WORDS-1:0] mask_low_cleared;

  assign mask_low_cleared = mask_q & (mask_q - WORDS'(1));

  always_comb begin
    mask_d = mask_q;
    if (load_i) begin
      mask_d = mask_i;
    end else if (step_i) begin
      mask_d = mask_low_cleared;
    end
  end

  always_comb begin
    word_o = '0;
    for (int i = int'(WORDS) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        word_o = WORD_W'(i);
      end
    end
  end

  assign last_o = (mask_q != '0) && (mask_low_cleared == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/llc_lookup_pipe.sv
// LLC set lookup: finds hit and empty ways, reports the scan way's owned mask,
// then streams one owner beat per owned word of that way.
module llc_lookup_pipe
  import llc_lookup_pipe_pkg::*;
#(
  parameter int unsigned WAYS      = 16,
  parameter int unsigned WORDS     = 4,
  parameter int unsigned WORD_BITS = 64,
  parameter int unsigned ID_WIDTH  = LLC_ID_WIDTH,
  parameter int unsigned TAG_W     = 20,
  localparam int unsigned WAY_W    = $clog2(WAYS),
  localparam int unsigned WORD_W   = $clog2(WORDS),
  localparam int unsigned CNT_W    = WORD_W + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [1:0]                             req_mode,
  input  logic [TAG_W-1:0]                       req_tag,
  input  logic [WAYS-1:0][TAG_W-1:0]             tags_buf,
  input  llc_state_t [WAYS-1:0]                  states_buf,
  input  logic [WAYS-1:0][WORDS-1:0]             owners_buf,
  input  logic [WAYS-1:0][WORDS*WORD_BITS-1:0]   lines_buf,
  input  logic [WAY_W-1:0]                       evict_way,
  output logic                                   resp_valid,
  input  logic                                   resp_ready,
  output logic                                   resp_tag_hit,
  output logic                                   resp_empty_found,
  output logic [WAY_W-1:0]                       resp_way_hit,
  output logic [WAY_W-1:0]                       resp_empty_way,
  output logic [WORDS-1:0]                       resp_owned_mask,
  output logic [CNT_W-1:0]                       resp_owned_cnt,
  output logic                                   own_valid,
  input  logic                                   own_ready,
  output logic [WORD_W-1:0]                      own_word,
  output logic [ID_WIDTH-1:0]                    own_id,
  output logic                                   own_last
);

  lookup_fsm_e state_d, state_q;
  logic        rdy_d, rdy_q;
  logic [1:0]  mode_d, mode_q;
  logic        tag_hit_d, tag_hit_q;
  logic        empty_found_d, empty_found_q;
  logic [WAY_W-1:0] way_hit_d, way_hit_q;
  logic [WAY_W-1:0] empty_way_d, empty_way_q;
  logic [WORDS-1:0] owned_mask_d, owned_mask_q;
  logic [CNT_W-1:0] owned_cnt_d, owned_cnt_q;
  logic [WORDS-1:0][ID_WIDTH-1:0] ids_d, ids_q;

  logic             hit, empty;
  logic [WAY_W-1:0] hit_way, empty_way, scan_way;
  logic             scan_en;
  logic [WORDS-1:0] mask_new;
  logic [CNT_W-1:0] cnt_new;
  logic [WORDS-1:0][ID_WIDTH-1:0] ids_new;
  logic             capture;
  logic             scan_step, scan_last;
  logic [WORD_W-1:0] scan_word;
  logic             unused_lines;

  // Only the ID slices of the line data are consumed.
  assign unused_lines = ^lines_buf;

  // Descending loop so the lowest matching index is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    empty     = 1'b0;
    empty_way = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (tags_buf[i] == req_tag && states_buf[i] != LLC_I) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (states_buf[i] == LLC_I) begin
        empty     = 1'b1;
        empty_way = WAY_W'(i);
      end
    end
  end

  always_comb begin
    scan_en  = 1'b1;
    scan_way = evict_way;
    if (req_mode != REQ_EVICT_SCAN) begin
      if (hit) begin
        scan_way = hit_way;
      end else if (empty) begin
        scan_en = 1'b0;
      end
    end
    mask_new = scan_en ? owners_buf[scan_way] : '0;
    cnt_new  = '0;
    ids_new  = '0;
    for (int w = 0; w < int'(WORDS); w++) begin
      cnt_new = cnt_new + CNT_W'(mask_new[w]);
      if (scan_en) begin
        ids_new[w] = lines_buf[scan_way][w*WORD_BITS +: ID_WIDTH];
      end
    end
  end

  assign capture = (state_q == StIdle) && rdy_q && req_valid && (req_mode != REQ_RSVD);

  always_comb begin
    state_d       = state_q;
    rdy_d         = 1'b1;
    mode_d        = mode_q;
    tag_hit_d     = tag_hit_q;
    empty_found_d = empty_found_q;
    way_hit_d     = way_hit_q;
    empty_way_d   = empty_way_q;
    owned_mask_d  = owned_mask_q;
    owned_cnt_d   = owned_cnt_q;
    ids_d         = ids_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d      = StResp;
          mode_d       = req_mode;
          owned_mask_d = mask_new;
          owned_cnt_d  = cnt_new;
          ids_d        = ids_new;
          if (req_mode == REQ_EVICT_SCAN) begin
            tag_hit_d     = 1'b0;
            empty_found_d = 1'b0;
            way_hit_d     = '0;
            empty_way_d   = '0;
          end else begin
            tag_hit_d     = hit;
            empty_found_d = empty;
            way_hit_d     = hit_way;
            empty_way_d   = empty_way;
          end
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = (mode_q == REQ_LOOKUP || owned_mask_q == '0) ? StIdle : StScan;
        end
      end
      StScan: begin
        if (own_ready && scan_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      rdy_q         <= 1'b0;
      mode_q        <= REQ_LOOKUP;
      tag_hit_q     <= 1'b0;
      empty_found_q <= 1'b0;
      way_hit_q     <= '0;
      empty_way_q   <= '0;
      owned_mask_q  <= '0;
      owned_cnt_q   <= '0;
      ids_q         <= '0;
    end else begin
      state_q       <= state_d;
      rdy_q         <= rdy_d;
      mode_q        <= mode_d;
      tag_hit_q     <= tag_hit_d;
      empty_found_q <= empty_found_d;
      way_hit_q     <= way_hit_d;
      empty_way_q   <= empty_way_d;
      owned_mask_q  <= owned_mask_d;
      owned_cnt_q   <= owned_cnt_d;
      ids_q         <= ids_d;
    end
  end

  assign scan_step = (state_q == StScan) && own_ready;

  llc_owned_word_scanner #(
    .WORDS (WORDS)
  ) u_scanner (
    .clk_i  (clk),
    .rst_ni (rst),
    .load_i (capture),
    .mask_i (mask_new),
    .step_i (scan_step),
    .word_o (scan_word),
    .last_o (scan_last)
  );

  assign req_ready        = (state_q == StIdle) && rdy_q;
  assign resp_valid       = (state_q == StResp);
  assign resp_tag_hit     = tag_hit_q;
  assign resp_empty_found = empty_found_q;
  assign resp_way_hit     = way_hit_q;
  assign resp_empty_way   = empty_way_q;
  assign resp_owned_mask  = owned_mask_q;
  assign resp_owned_cnt   = owned_cnt_q;
  assign own_valid        = (state_q == StScan);
  assign own_word         = scan_word;
  assign own_id           = ids_q[scan_word];
  assign own_last         = own_valid && scan_last;

endmodule
